// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU/branch encodings, forwarding selects and
// the multiply/divide sequencer states.
package exec_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'b0000,
        OpSub  = 4'b0001,
        OpAnd  = 4'b0010,
        OpOr   = 4'b0011,
        OpXor  = 4'b0100,
        OpSlt  = 4'b0101,
        OpSltu = 4'b0110,
        OpSll  = 4'b0111,
        OpSrl  = 4'b1000,
        OpSra  = 4'b1001,
        OpMul  = 4'b1010,
        OpMulh = 4'b1011,
        OpDiv  = 4'b1100,
        OpDivu = 4'b1101,
        OpRem  = 4'b1110,
        OpRemu = 4'b1111
    } alu_op_t;

    typedef enum logic [2:0] {
        BrEq  = 3'b000,
        BrNe  = 3'b001,
        BrLt  = 3'b010,
        BrGe  = 3'b011,
        BrLtu = 3'b100,
        BrGeu = 3'b101
    } branch_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_t;

    // Codes 1010..1111 are the iterative multiply/divide operations.
    function automatic logic is_muldiv(alu_op_t op);
        return op[3] & (op[2] | op[1]);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide: one shift-add or restoring-divide step per cycle
// on operand magnitudes, with sign correction applied when the result is latched.
module muldiv_unit
    import exec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            active,
    output logic [XLEN-1:0] result
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, result_q, result_d;
    alu_op_t          op_q, op_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, div_zero_q, div_zero_d;

    alu_op_t          op_in;
    logic             issue, signed_in, mul_in, sa, sb, mul_q;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN:0]    sum, addend, shifted, diff;
    logic [XLEN-1:0]  step_hi, step_lo, quot_s, rem_s;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]  final_res;

    assign op_in     = alu_op_t'(op);
    // Reset must silence the combinational issue stall as well as the state.
    assign issue     = start & ~flush & ~rst;
    assign signed_in = op_in inside {OpMul, OpMulh, OpDiv, OpRem};
    assign mul_in    = op_in inside {OpMul, OpMulh};
    assign sa        = signed_in & a[XLEN-1];
    assign sb        = signed_in & b[XLEN-1];
    assign abs_a     = sa ? -a : a;
    assign abs_b     = sb ? -b : b;
    assign mul_q     = op_q inside {OpMul, OpMulh};

    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, mcand_q};
        addend  = lo_q[0] ? sum : {1'b0, hi_q};
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, mcand_q};
        if (mul_q) begin
            step_hi = addend[XLEN:1];
            step_lo = {addend[0], lo_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            step_hi = diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            step_hi = shifted[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b0};
        end
        prod   = {step_hi, step_lo};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quot_s = (neg_a_q ^ neg_b_q) ? -step_lo : step_lo;
        rem_s  = neg_a_q ? -step_hi : step_hi;
        unique case (op_q)
            OpMul:         final_res = prod_s[XLEN-1:0];
            OpMulh:        final_res = prod_s[2*XLEN-1:XLEN];
            OpDiv, OpDivu: final_res = div_zero_q ? '1 : quot_s;
            OpRem, OpRemu: final_res = rem_s;
            default:       final_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            result_q   <= '0;
            op_q       <= OpAdd;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mcand_q    <= mcand_d;
            result_q   <= result_d;
            op_q       <= op_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mcand_d    = mcand_q;
        result_d   = result_q;
        op_d       = op_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    op_d       = op_in;
                    neg_a_d    = sa;
                    neg_b_d    = sb;
                    div_zero_d = (b == '0);
                    hi_d       = '0;
                    lo_d       = mul_in ? abs_b : abs_a;
                    mcand_d    = mul_in ? abs_a : abs_b;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == BUSY) | ((state_q == IDLE) & issue);
        done   = (state_q == DONE) & ~flush;
        active = (state_q != IDLE);
        result = result_q;
    end

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch condition and PC target,
// with an iterative multiply/divide unit that stalls the pipeline while it runs.
module execute_muldiv
    import exec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validE,
    input  logic            flushE,
    input  logic            ALUSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      BranchTypeE,
    input  logic [XLEN-1:0] rs1_dataE,
    input  logic [XLEN-1:0] rs2_dataE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            cond_trueE,
    output logic            StallMD,
    output logic            MDDoneE
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_op_t         op;
    branch_t         br;
    logic [XLEN-1:0] src_a, src_b, alu_res, md_result;
    logic [SHW-1:0]  shamt;
    logic            cond, md_active;

    assign op    = alu_op_t'(ALUControlE);
    assign br    = branch_t'(BranchTypeE);
    assign src_b = ALUSrcE ? ImmExtE : WriteDataE;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        case (ForwardAE)
            FWD_W:   src_a = ResultW;
            FWD_M:   src_a = ALUResultM;
            default: src_a = rs1_dataE;
        endcase
        case (ForwardBE)
            FWD_W:   WriteDataE = ResultW;
            FWD_M:   WriteDataE = ALUResultM;
            default: WriteDataE = rs2_dataE;
        endcase
    end

    always_comb begin
        case (op)
            OpAdd:   alu_res = src_a + src_b;
            OpSub:   alu_res = src_a - src_b;
            OpAnd:   alu_res = src_a & src_b;
            OpOr:    alu_res = src_a | src_b;
            OpXor:   alu_res = src_a ^ src_b;
            OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OpSltu:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OpSll:   alu_res = src_a << shamt;
            OpSrl:   alu_res = src_a >> shamt;
            OpSra:   alu_res = $unsigned($signed(src_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (br)
            BrEq:    cond = (src_a == src_b);
            BrNe:    cond = (src_a != src_b);
            BrLt:    cond = ($signed(src_a) < $signed(src_b));
            BrGe:    cond = ($signed(src_a) >= $signed(src_b));
            BrLtu:   cond = (src_a < src_b);
            BrGeu:   cond = (src_a >= src_b);
            default: cond = 1'b0;
        endcase
    end

    muldiv_unit #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (validE & is_muldiv(op)),
        .flush  (flushE),
        .op     (ALUControlE),
        .a      (src_a),
        .b      (src_b),
        .busy   (StallMD),
        .done   (MDDoneE),
        .active (md_active),
        .result (md_result)
    );

    assign ALUResultE = md_active ? md_result : alu_res;
    assign cond_trueE = cond & ~md_active;
    assign PCTargetE  = PCE + ImmExtE;

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomised and directed bench for execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, validE, flushE, ALUSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  BranchTypeE;
    logic [31:0] rs1_dataE, rs2_dataE, ImmExtE, PCE, ALUResultM, ResultW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultE, WriteDataE, PCTargetE;
    logic        cond_trueE, StallMD, MDDoneE;

    always #5 clk = ~clk;

    execute_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .validE(validE), .flushE(flushE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .BranchTypeE(BranchTypeE), .rs1_dataE(rs1_dataE),
        .rs2_dataE(rs2_dataE), .ImmExtE(ImmExtE), .PCE(PCE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ALUResultM(ALUResultM), .ResultW(ResultW),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
        .cond_trueE(cond_trueE), .StallMD(StallMD), .MDDoneE(MDDoneE)
    );

    int n_vec = 0;
    int n_err = 0;

    bit          chk_en = 1'b0;
    bit          exp_res_chk, exp_cond_chk;
    logic [31:0] exp_res, exp_wd, exp_pct, last_md;
    logic        exp_cond, exp_stall, exp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r, w, m);
        case (s)
            2'b01:   return w;
            2'b10:   return m;
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return (a < b) ? 32'd1 : 32'd0;
            7: return a << sh;
            8: return a >> sh;
            9: return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic br_ref(input int br, input logic [31:0] a, b);
        case (br)
            0: return a == b;
            1: return a != b;
            2: return $signed(a) < $signed(b);
            3: return $signed(a) >= $signed(b);
            4: return a < b;
            5: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] md_ref(input int op, input logic [31:0] a, b);
        longint p;
        int     sa, sb;
        logic   ovf;
        p   = longint'($signed(a)) * longint'($signed(b));
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            10: return p[31:0];
            11: return p[63:32];
            12: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            14: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            15: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(StallMD), 32'(exp_stall));
            check("done", 32'(MDDoneE), 32'(exp_done));
            check("wdata", WriteDataE, exp_wd);
            check("pctarget", PCTargetE, exp_pct);
            if (exp_cond_chk) check("cond", 32'(cond_trueE), 32'(exp_cond));
            if (exp_res_chk) check("result", ALUResultE, exp_res);
            if (MDDoneE) last_md = ALUResultE;
        end
    end

    // Expectations for an idle unit given whatever is currently on the inputs.
    task automatic idle_expect();
        logic [31:0] sa, sb;
        sa           = fwd(ForwardAE, rs1_dataE, ResultW, ALUResultM);
        exp_wd       = fwd(ForwardBE, rs2_dataE, ResultW, ALUResultM);
        sb           = ALUSrcE ? ImmExtE : exp_wd;
        exp_res      = alu_ref(int'(ALUControlE), sa, sb);
        exp_cond     = br_ref(int'(BranchTypeE), sa, sb);
        exp_pct      = PCE + ImmExtE;
        exp_stall    = 1'b0;
        exp_done     = 1'b0;
        exp_res_chk  = 1'b1;
        exp_cond_chk = 1'b1;
        chk_en       = 1'b1;
    endtask

    task automatic do_alu(input int op, input int br, input logic [31:0] r1, r2,
                          input logic [1:0] fa, fb, input logic as,
                          input logic [31:0] m, w, imm);
        validE = 1'b1; flushE = 1'b0;
        ALUControlE = 4'(op); BranchTypeE = 3'(br);
        rs1_dataE = r1; rs2_dataE = r2; ForwardAE = fa; ForwardBE = fb; ALUSrcE = as;
        ALUResultM = m; ResultW = w; ImmExtE = imm; PCE = $urandom;
        idle_expect();
        @(posedge clk); #1;
    endtask

    // kind: 0 = run to completion, 1 = flushE at cycle 'at', 2 = rst at cycle 'at'.
    task automatic do_md(input int op, input logic [31:0] r1, r2, input logic [1:0] fa, fb,
                         input logic as, input logic [31:0] m, w, imm, newm,
                         input int kind, input int at);
        logic [31:0] sa, sb, expv;
        validE = 1'b1; flushE = 1'b0;
        ALUControlE = 4'(op); BranchTypeE = 3'($urandom_range(0, 7));
        rs1_dataE = r1; rs2_dataE = r2; ForwardAE = fa; ForwardBE = fb; ALUSrcE = as;
        ALUResultM = m; ResultW = w; ImmExtE = imm; PCE = $urandom;
        sa = fwd(fa, r1, w, m);
        exp_wd = fwd(fb, r2, w, m);
        sb = as ? imm : exp_wd;
        expv = md_ref(op, sa, sb);
        exp_pct = PCE + imm; exp_stall = 1'b1; exp_done = 1'b0;
        exp_res_chk = 1'b0; exp_cond_chk = 1'b0; chk_en = 1'b1;
        last_md = 32'hDEAD_BEEF;
        for (int c = 1; c <= XLEN + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                // Forwarding sources move on after issue; the captured operands must not.
                ALUResultM = newm;
                ResultW    = ~w;
                exp_wd     = fwd(fb, r2, ResultW, ALUResultM);
            end
            exp_cond_chk = 1'b1; exp_cond = 1'b0;
            exp_stall    = (c <= XLEN);
            exp_done     = (c == XLEN + 1);
            exp_res_chk  = (c == XLEN + 1);
            exp_res      = expv;
            if (kind == 1 && c == at) begin
                flushE = 1'b1; exp_done = 1'b0; exp_res_chk = 1'b0;
                @(posedge clk); #1;
                flushE = 1'b0; validE = 1'b0;
                idle_expect();
                repeat (XLEN + 2) begin @(posedge clk); #1; end
                return;
            end
            if (kind == 2 && c == at) begin
                #2; chk_en = 1'b0; rst = 1'b1;
                #1;
                check("rst_stall", 32'(StallMD), 32'd0);
                check("rst_done", 32'(MDDoneE), 32'd0);
                @(posedge clk); #1;
                validE = 1'b0; rst = 1'b0;
                idle_expect();
                repeat (XLEN + 2) begin @(posedge clk); #1; end
                return;
            end
        end
        @(posedge clk); #1;
        validE = 1'b0;
        idle_expect();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; validE = 1'b0; flushE = 1'b0; ALUSrcE = 1'b0;
        ALUControlE = 4'd0; BranchTypeE = 3'd0; rs1_dataE = '0; rs2_dataE = '0;
        ImmExtE = '0; PCE = '0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        ALUResultM = '0; ResultW = '0;
        #2;
        check("reset_stall", 32'(StallMD), 32'd0);
        check("reset_done", 32'(MDDoneE), 32'd0);
        validE = 1'b1; ALUControlE = 4'd10;
        #1;
        check("reset_gate_stall", 32'(StallMD), 32'd0);
        validE = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        do_alu(0, 1, 32'd10, 32'd20, 2'b10, 2'b00, 1'b0, 32'd100, 32'd0, 32'd0);
        check("t1_add", ALUResultE, 32'd120);
        check("t1_stall", 32'(StallMD), 32'd0);
        do_alu(0, 1, 32'd5, 32'd5, 2'b00, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0);
        check("t1_bne", 32'(cond_trueE), 32'd0);

        do_md(10, 32'd7, 32'hFFFF_FFFD, 2'b00, 2'b00, 1'b0, $urandom, $urandom, $urandom,
              $urandom, 0, 0);
        check("t2_mul", last_md, 32'hFFFF_FFEB);
        do_md(11, 32'h8000_0000, 32'h8000_0000, 2'b00, 2'b00, 1'b0, $urandom, $urandom,
              $urandom, $urandom, 0, 0);
        check("t2_mulh", last_md, 32'h4000_0000);

        do_md(10, 32'd123, 32'd7, 2'b10, 2'b00, 1'b0, 32'd6, $urandom, $urandom, 32'd0, 0, 0);
        check("t3_capture", last_md, 32'd42);

        do_md(12, 32'd100, 32'd0, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 0, 0);
        check("t4_div0", last_md, 32'hFFFF_FFFF);
        do_md(14, 32'd100, 32'd0, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 0, 0);
        check("t4_rem0", last_md, 32'd100);
        do_md(12, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 0, 0);
        check("t4_div_ovf", last_md, 32'h8000_0000);
        do_md(14, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 0, 0);
        check("t4_rem_ovf", last_md, 32'd0);

        do_alu(0, 2, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        check("t5_blt", 32'(cond_trueE), 32'd1);
        do_alu(0, 4, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        check("t5_bltu", 32'(cond_trueE), 32'd0);
        do_alu(0, 5, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 1'b0, 0, 0, 0);
        check("t5_bgeu", 32'(cond_trueE), 32'd1);

        do_md(12, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 2, 10);
        check("t6_rst_nodone", last_md, 32'hDEAD_BEEF);
        do_md(13, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 0, 0);
        check("t6_divu", last_md, 32'd14);
        do_md(15, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 0, 0);
        check("t6_remu", last_md, 32'd2);
        do_md(13, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 1, 5);
        check("t6_flush_nodone", last_md, 32'hDEAD_BEEF);
        do_md(10, 32'd9, 32'd9, 2'b00, 2'b00, 1'b0, 0, 0, 0, $urandom, 1, XLEN + 1);
        check("t6_flush_done", last_md, 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            do_alu($urandom_range(0, 9), $urandom_range(0, 7), pick(), pick(),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   pick(), pick(), pick());
        end
        for (int i = 0; i < 14; i++) begin
            do_md($urandom_range(10, 15), pick(), pick(), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(), pick(),
                  $urandom, 0, 0);
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Parametrised successor of the pipelined execute stage. It keeps the register/forwarding operand muxes, the ALU, branch-condition and PC-target logic. It adds an iterative multi-cycle multiply/divide unit (RV32M subset) that stalls the pipeline while it runs. Sits between the ID/EX and EX/MEM pipeline registers; StallMD feeds the hazard unit.

Parameters:
XLEN, 32, datapath width (≥8, power of 2)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
validE  in  1  E holds a real instruction (0 = bubble)
flushE  in  1  synchronous abort of E-stage instruction
ALUSrcE  in  1  SrcB select: 0 = forwarded rs2, 1 = ImmExtE
ALUControlE  in  4  operation (alu_op_t)
BranchTypeE  in  3  branch comparison (branch_t)
rs1_dataE, rs2_dataE, ImmExtE, PCE  in  XLEN  ID/EX operands
ForwardAE, ForwardBE  in  2  00 = reg, 01 = ResultW, 10 = ALUResultM, 11 = treated as 00
ALUResultM, ResultW  in  XLEN  forwarding sources
ALUResultE  out  XLEN  ALU or mul/div result
WriteDataE  out  XLEN  forwarded rs2 (store data)
PCTargetE  out  XLEN  PCE + ImmExtE, wraps modulo 2^XLEN
cond_trueE  out  1  branch condition met
StallMD  out  1  hold F/D/E, bubble M
MDDoneE  out  1  one-cycle pulse: mul/div result valid on ALUResultE

Behaviour:
- Operand selection:
  - SrcA = fwd(ForwardAE, rs1).
  - WriteDataE = fwd(ForwardBE, rs2).
  - SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- Single-cycle ops are combinational: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
  - Shift amount = SrcB[log2(XLEN)-1:0].
  - Arithmetic wraps modulo 2^XLEN.
  - Unused codes produce 0.
- Mul/div ops: MUL 1010, MULH 1011 (signed×signed high), DIV 1100, DIVU 1101, REM 1110, REMU 1111.
- Branch conditions compare SrcA vs SrcB: BEQ 000, BNE 001, BLT 010, BGE 011, BLTU 100, BGEU 101. Other codes give cond_trueE = 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if validE & mul/div op & !flushE:
    - capture SrcA, SrcB, op and signs into internal registers
    - StallMD = 1 combinationally this cycle
    - go to BUSY, counter = 0
  - BUSY: one shift-add (mul) or restoring-division step per cycle on the absolute values. StallMD = 1. After XLEN steps go to DONE.
  - DONE:
    - apply sign correction and select result into the result register
    - StallMD = 0, MDDoneE = 1, ALUResultE = result register
    - always go to IDLE next cycle; the pipeline advances on this edge, so no re-issue.
- Latency is fixed and data-independent: StallMD high for XLEN+1 cycles (issue + XLEN); result on cycle XLEN+1 after issue.
- Operands are captured at issue. Forwarding sources changing during BUSY must not affect the result, since M is bubbled while stalled.
- Division corner cases follow RISC-V and keep the same latency:
  - divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - signed overflow (−2^(XLEN−1) / −1): DIV → −2^(XLEN−1); REM → 0.
- MULH: magnitude product 2·XLEN bits, negated if operand signs differ; upper half returned.
- During BUSY/DONE, ALUResultE shows the result register and cond_trueE = 0.
- flushE in BUSY or DONE returns to IDLE next edge. StallMD is combinational from state and drops in the cycle after the flush edge. No MDDoneE pulse.
- validE = 0 in IDLE never starts the unit.
- Reset (async, any state): state IDLE, counter 0, all internal registers 0. StallMD = 0 and MDDoneE = 0 immediately.

Decomposition:
- Package exec_pkg:
  - alu_op_t (4-bit enum), branch_t (3-bit enum)
  - forward select constants FWD_REG, FWD_W, FWD_M
  - md_state_t {IDLE, BUSY, DONE}
  - function is_muldiv(alu_op_t)
- Sub-module muldiv_unit #(XLEN), holding the FSM, counter and shift datapath.
  - Ports: clk, rst, start, flush, op, a, b → busy, done, result.
  - execute_muldiv holds the forwarding muxes, ALU, branch logic and result select.

Test Plan:
1. ADD, rs1 = 10, rs2 = 20, ForwardAE = 10, ALUResultM = 100 → ALUResultE = 120, StallMD = 0; BNE on rs1 = rs2 = 5 (no forwarding) → cond_trueE = 0.
2. MUL, validE = 1, rs1 = 7, rs2 = 0xFFFFFFFD → StallMD high exactly 33 cycles, then ALUResultE = 0xFFFFFFEB with MDDoneE high one cycle; MULH 0x80000000 × 0x80000000 → 0x40000000.
3. Operand capture: MUL with ForwardAE = 10, ALUResultM = 6, rs2 = 7; set ALUResultM = 0 the cycle after issue → result 42.
4. DIV 100 / 0 → 0xFFFFFFFF; REM 100 / 0 → 100; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0; every case takes 33 stall cycles.
5. BLT rs1 = 0xFFFFFFFF, rs2 = 1 → cond_trueE = 1; BLTU same operands → 0; BGEU → 1.
6. Assert rst during BUSY cycle 10 → StallMD = 0 with no clock edge, no MDDoneE. Then DIVU 100 / 7 → 14 and REMU → 2. Then flushE at BUSY cycle 5 → IDLE, no MDDoneE.
